// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants, FSM state type and helpers for the register write arbiter.
package cpu_pkg;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_STALL
  } starve_state_t;

  function automatic int unsigned pop_count(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction
endpackage

// File: rtl/reg_write_arbiter_if.sv
// Bundle of WB, multiply, ID-stage and register-file port signals around the arbiter.
interface reg_write_arbiter_if;
  import cpu_pkg::*;

  logic              wb_we;
  logic [REG_W-1:0]  wb_rw;
  logic [DATA_W-1:0] wb_wd;
  logic              mul_issue;
  logic [REG_W-1:0]  mul_dst;
  logic              mul_valid;
  logic [REG_W-1:0]  mul_rw;
  logic [DATA_W-1:0] mul_wd;
  logic              mul_ready;
  logic [REG_W-1:0]  rs_id;
  logic [REG_W-1:0]  rt_id;
  logic [REG_W-1:0]  dst_id;
  logic              hazard;
  logic              stall_req;
  logic              rf_we;
  logic [REG_W-1:0]  rf_rw;
  logic [DATA_W-1:0] rf_wd;

  modport slave (
    input  wb_we, wb_rw, wb_wd, mul_issue, mul_dst, mul_valid, mul_rw, mul_wd,
           rs_id, rt_id, dst_id,
    output mul_ready, hazard, stall_req, rf_we, rf_rw, rf_wd
  );

  modport master (
    output wb_we, wb_rw, wb_wd, mul_issue, mul_dst, mul_valid, mul_rw, mul_wd,
           rs_id, rt_id, dst_id,
    input  mul_ready, hazard, stall_req, rf_we, rf_rw, rf_wd
  );
endinterface

// File: rtl/reg_write_arbiter_rw_fifo.sv
// Synchronous FIFO of queued multiply results ({rw, wd}); head is visible combinationally.
module rw_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter: WB priority, multiply-result FIFO, pending scoreboard
// and starvation stall. Optional same-cycle multiply bypass under RF_WR_BYPASS_EN.
module reg_write_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst_n,
  reg_write_arbiter_if.slave bus
);
  localparam int unsigned ENT_W = REG_W + DATA_W;
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

  logic              wb_eff;
  logic              full, empty, push, pop, byp;
  logic [ENT_W-1:0]  head;
  logic              rf_we;
  logic [REG_W-1:0]  rf_rw;
  logic [DATA_W-1:0] rf_wd;
  logic [31:0]       pend, pend_set, pend_clr;
  logic              issue_blocked;
  starve_state_t     state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              stall_req;

  assign wb_eff = bus.wb_we && (bus.wb_rw != REG_ZERO);

  rw_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({bus.mul_rw, bus.mul_wd}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_comb begin
    rf_we = 1'b0;
    rf_rw = '0;
    rf_wd = '0;
    pop   = 1'b0;
    byp   = 1'b0;
    if (wb_eff) begin
      rf_we = 1'b1;
      rf_rw = bus.wb_rw;
      rf_wd = bus.wb_wd;
    end else if (!empty) begin
      rf_we = 1'b1;
      rf_rw = head[ENT_W-1:DATA_W];
      rf_wd = head[DATA_W-1:0];
      pop   = 1'b1;
`ifdef RF_WR_BYPASS_EN
    end else if (bus.mul_valid && (bus.mul_rw != REG_ZERO)) begin
      rf_we = 1'b1;
      rf_rw = bus.mul_rw;
      rf_wd = bus.mul_wd;
      byp   = 1'b1;
`else
    end else begin
      byp   = 1'b0;
`endif
    end
  end

  // Zero-register results are acknowledged through mul_ready but never stored.
  assign push = bus.mul_valid && !full && (bus.mul_rw != REG_ZERO) && !byp;

  assign bus.mul_ready = !full;
  assign bus.rf_we     = rf_we;
  assign bus.rf_rw     = rf_rw;
  assign bus.rf_wd     = rf_wd;

  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (bus.mul_issue && (bus.mul_dst != REG_ZERO)) pend_set[bus.mul_dst] = 1'b1;
    if (pop || byp) pend_clr[rf_rw] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= (pend & ~pend_clr) | pend_set;
  end

  assign issue_blocked = (pop_count(pend) == DEPTH);

  always_comb begin
    bus.hazard = issue_blocked;
    if (bus.rs_id  != REG_ZERO && pend[bus.rs_id])  bus.hazard = 1'b1;
    if (bus.rt_id  != REG_ZERO && pend[bus.rt_id])  bus.hazard = 1'b1;
    if (bus.dst_id != REG_ZERO && pend[bus.dst_id]) bus.hazard = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      stall_req <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      stall_req <= (state_nx == ST_STALL);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (full && wb_eff) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (pop) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else if (full) begin
          if (cnt == CNT_LAST) begin
            state_nx = ST_STALL;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      ST_STALL: begin
        cnt_nx = '0;
        if (empty) state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign bus.stall_req = stall_req;
endmodule
